polyveck_decompose_stream: RTL
==============================

// Module: polyveck_decompose_stream
// PURPOSE
//  Sequential, parametrised Dilithium Decompose over a K-polynomial vector: each coeff a -> (a1, a0), a = a1*2*GAMMA2 + a0.
//  Streams LANES coeffs/beat over valid/ready instead of a full-width combinational array; GAMMA2 mode selectable at build time.
//  Sits between the w = A*y NTT/INTT path and the w1 packer / hint logic in sign and verify.
// PARAMETERS
//  K       6        polynomials per vector
//  N       256      coefficients per polynomial
//  COEF_W  32       signed coefficient width
//  LANES   4        coefficients per beat; must divide N (power of 2)
//  GAMMA2  261888   (Q-1)/32; the only other legal value is 95232 = (Q-1)/88; any other value -> elaboration error
//  Q       8380417  modulus
// PORTS
//  clk         in   1              clock
//  rst         in   1              asynchronous, active-high reset
//  in_valid    in   1              input beat valid
//  in_ready    out  1              input beat accepted when in_valid&in_ready
//  in_data     in   LANES*COEF_W   coeffs, lane i at [COEF_W*i +: COEF_W], range [0,Q)
//  out_valid   out  1              output beat valid
//  out_ready   in   1              downstream accepts
//  out_a1      out  LANES*COEF_W   high parts, zero-extended
//  out_a0      out  LANES*COEF_W   low parts, sign-extended, range (-GAMMA2, GAMMA2]
//  out_poly    out  3              polynomial index 0..K-1 of this beat
//  out_last_p  out  1              last beat of a polynomial
//  out_last_v  out  1              last beat of the vector
//  range_err   out  1              sticky, only with DECOMP_RANGE_CHECK_EN (tied 0 otherwise)
// BEHAVIOUR
//  - Reset: in_ready=0 during reset, 1 first cycle after; out_valid/out_a1/out_a0/out_poly/out_last_*/range_err = 0; counters 0.
//  - Per lane: t=(a+127)>>>7;
//    GAMMA2=(Q-1)/32: a1=((t*1025+2^21)>>>22)&15
//    GAMMA2=(Q-1)/88: a1=(t*11275+2^23)>>>24; if (43-a1)<0 then a1=0
//    a0=a-a1*2*GAMMA2; if a0>(Q-1)/2 then a0-=Q. Products held in >=48-bit signed intermediates.
//  - 2-stage pipeline: S1 registers t and the a1 product; S2 registers a1/a0. Latency: accept cycle N -> out_valid cycle N+2 (no stall).
//  - Full throughput: one beat/cycle while out_ready=1. Backpressure: stage advances only when next stage empty or draining;
//    in_ready = !(S1 full & S2 full & !out_ready). No beat dropped/duplicated; out_* held stable while out_valid&!out_ready.
//  - Beat counter on input accept: BEATS_P=N/LANES per poly, K polys per vector; tags (poly, last_p, last_v) travel with data.
//    After last_v beat counters wrap to 0; next vector starts immediately, no bubble.
//  - Simultaneous S2 output handshake + S1 advance + new input accept in one cycle is legal and must not lose data.
//  - Async reset mid-vector: pipeline flushed, counters to 0; next accepted beat is poly 0 beat 0.
//  - Inputs outside [0,Q): outputs are defined by the formula above (no saturation).
// CONFIGURATION
//  DECOMP_RANGE_CHECK_EN defined: any accepted lane with a<0 or a>=Q sets range_err (sticky until rst); data still processed.
//  Undefined: no compare logic; range_err constant 0.
// TESTING
//  1. GAMMA2=261888, lanes {0,261888,261889,8380416} -> a1 {0,0,1,0}, a0 {0,261888,-261887,-1}.
//  2. GAMMA2=95232, lane a=95233 -> a1=1, a0=-95231; a=8380416 -> a1=0, a0=-1.
//  3. K=6,N=256,LANES=4: stream 384 beats, out_ready=1 -> 384 outputs, out_last_p on beats 63,127,..., out_last_v on 383, matches C model.
//  4. Random out_ready (50%) + random in_valid -> output sequence identical to no-stall run; data stable during stalls.
//  5. rst pulsed at beat 100 -> out_valid=0 in the same cycle; next vector tags restart at poly 0, last_v after 384 more beats.
//  6. RANGE_CHECK_EN: inject a=8380417 on lane 2 -> range_err=1 the cycle after accept, stays 1 until rst.

Source files
------------

// File: rtl/polyveck_decompose_stream.sv
// Streaming Dilithium Decompose: LANES coeffs/beat -> (a1, a0) with poly/last tags, 2-stage pipeline.
// Optional build macro DECOMP_RANGE_CHECK_EN enables the sticky range_err flag for inputs outside [0,Q).
`timescale 1ns/1ps

module polyveck_decompose_lane #(
  parameter int COEF_W = 32,
  parameter int GAMMA2 = 261888,
  parameter int Q      = 8380417
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld1,
  input  logic              ld2,
  input  logic [COEF_W-1:0] a,
  output logic [COEF_W-1:0] a1,
  output logic [COEF_W-1:0] a0
);
  localparam int W   = 48;
  localparam bit G32 = (GAMMA2 == 261888);
  typedef logic signed [W-1:0] wide_t;

  function automatic wide_t sext(input logic [COEF_W-1:0] v);
    return wide_t'({{(W-COEF_W){v[COEF_W-1]}}, v});
  endfunction

  function automatic wide_t s1_prod(input logic [COEF_W-1:0] v);
    wide_t t;
    t = (sext(v) + wide_t'(127)) >>> 7;
    return t * (G32 ? wide_t'(1025) : wide_t'(11275));
  endfunction

  function automatic wide_t hi_part(input wide_t p);
    wide_t h;
    if (G32) begin
      h = ((p + wide_t'(1 << 21)) >>> 22) & wide_t'(15);
    end else begin
      h = (p + wide_t'(1 << 23)) >>> 24;
      if (wide_t'(43) - h < 0) h = '0;
    end
    return h;
  endfunction

  // centred remainder; the a = Q-1 corner folds to a0 = -1 through the > (Q-1)/2 wrap
  function automatic wide_t lo_part(input wide_t av, input wide_t h);
    wide_t r;
    r = av - h * wide_t'(2 * GAMMA2);
    if (r > wide_t'((Q - 1) / 2)) r = r - wide_t'(Q);
    return r;
  endfunction

  logic [COEF_W-1:0] a_q;
  wide_t             prod_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      prod_q <= '0;
      a1     <= '0;
      a0     <= '0;
    end else begin
      if (ld1) begin
        a_q    <= a;
        prod_q <= s1_prod(a);
      end
      if (ld2) begin
        a1 <= COEF_W'(hi_part(prod_q));
        a0 <= COEF_W'(lo_part(sext(a_q), hi_part(prod_q)));
      end
    end
  end
endmodule

module polyveck_decompose_stream #(
  parameter int K      = 6,
  parameter int N      = 256,
  parameter int COEF_W = 32,
  parameter int LANES  = 4,
  parameter int GAMMA2 = 261888,
  parameter int Q      = 8380417
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*COEF_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*COEF_W-1:0] out_a1,
  output logic [LANES*COEF_W-1:0] out_a0,
  output logic [2:0]              out_poly,
  output logic                    out_last_p,
  output logic                    out_last_v,
  output logic                    range_err
);
  localparam int STAGES  = 2;
  localparam int BEATS_P = N / LANES;
  localparam int BW      = (BEATS_P > 1) ? $clog2(BEATS_P) : 1;

  if (!(GAMMA2 == 261888 || GAMMA2 == 95232)) begin : g_bad_gamma
    $error("GAMMA2 must be 261888 or 95232");
  end
  if ((N % LANES) != 0) begin : g_bad_lanes
    $error("LANES must divide N");
  end

  typedef struct packed {
    logic [2:0] poly;
    logic       last_p;
    logic       last_v;
  } tag_t;

  logic [STAGES:1]              vld_pipe;
  tag_t                         tag1, tag2, tag_in;
  logic                         rdy_q, adv1, adv2, in_fire, ld2;
  logic [BW-1:0]                beat_cnt;
  logic [2:0]                   poly_cnt;
  logic [LANES-1:0][COEF_W-1:0] a1_v, a0_v;

  // a stage may load when it is empty or its contents move on this cycle
  assign adv2     = !vld_pipe[2] | out_ready;
  assign adv1     = !vld_pipe[1] | adv2;
  assign in_ready = rdy_q & adv1;
  assign in_fire  = in_valid & in_ready;
  assign ld2      = vld_pipe[1] & adv2;

  assign tag_in.poly   = poly_cnt;
  assign tag_in.last_p = (beat_cnt == BW'(BEATS_P - 1));
  assign tag_in.last_v = tag_in.last_p && (poly_cnt == 3'(K - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q    <= 1'b0;
      vld_pipe <= '0;
      tag1     <= '0;
      tag2     <= '0;
      beat_cnt <= '0;
      poly_cnt <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (adv1) vld_pipe[1] <= in_fire;
      if (adv2) vld_pipe[2] <= vld_pipe[1];
      if (in_fire) tag1 <= tag_in;
      if (ld2) tag2 <= tag1;
      if (in_fire) begin
        if (tag_in.last_p) begin
          beat_cnt <= '0;
          poly_cnt <= tag_in.last_v ? 3'd0 : poly_cnt + 3'd1;
        end else begin
          beat_cnt <= beat_cnt + BW'(1);
        end
      end
    end
  end

  polyveck_decompose_lane #(
    .COEF_W(COEF_W), .GAMMA2(GAMMA2), .Q(Q)
  ) u_lane [LANES-1:0] (
    .clk (clk),
    .rst (rst),
    .ld1 (in_fire),
    .ld2 (ld2),
    .a   (in_data),
    .a1  (a1_v),
    .a0  (a0_v)
  );

  assign out_valid  = vld_pipe[2];
  assign out_a1     = a1_v;
  assign out_a0     = a0_v;
  assign out_poly   = tag2.poly;
  assign out_last_p = tag2.last_p;
  assign out_last_v = tag2.last_v;

`ifdef DECOMP_RANGE_CHECK_EN
  logic oor;
  always_comb begin
    oor = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if ($signed(in_data[COEF_W*i +: COEF_W]) < 0 ||
          $signed(in_data[COEF_W*i +: COEF_W]) >= Q) oor = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                range_err <= 1'b0;
    else if (in_fire && oor) range_err <= 1'b1;
  end
`else
  assign range_err = 1'b0;
`endif
endmodule
